lsu_mem_master: RTL

- Load/store initiator between the single-cycle datapath and the word-only data RAM (256 x 32, word-addressed by addr[9:2], write on posedge when mem_write, combinational read gated by mem_read).
- Accepts byte, half and word loads and stores over a valid/ready request channel.
- Drives the RAM's addr/write_data/mem_read/mem_write and performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data on a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/lsu_mem_master.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store memory master
package lsu_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int LANE_W         = WORD_W / BYTES_PER_WORD;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - sub-word store merge and load extract/extend (little-endian lanes)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    output logic [WORD_W-1:0] merged_word,
    output logic [WORD_W-1:0] load_data
);

    // Bit offsets of the addressed byte lane and half-word; half ignores addr_lo[0].
    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [LANE_W-1:0] byte_v;
    logic [15:0]       half_v;

    assign byte_sh = {addr_lo, 3'b000};
    assign half_sh = {addr_lo[1], 4'b0000};
    assign byte_v  = old_word[byte_sh +: LANE_W];
    assign half_v  = old_word[half_sh +: 16];

    // Store merge: replace only the addressed lanes of the word read back from RAM.
    always_comb begin
        merged_word = old_word;
        case (size)
            SZ_BYTE: merged_word[byte_sh +: LANE_W] = wdata[LANE_W-1:0];
            SZ_HALF: merged_word[half_sh +: 16]     = wdata[15:0];
            SZ_WORD: merged_word                    = wdata;
            default: merged_word                    = old_word;
        endcase
    end

    // Load extract: pick the addressed lanes, then sign- or zero-extend.
    always_comb begin
        load_data = old_word;
        case (size)
            SZ_BYTE: load_data = {{(WORD_W-LANE_W){~is_unsigned & byte_v[LANE_W-1]}}, byte_v};
            SZ_HALF: load_data = {{(WORD_W-16){~is_unsigned & half_v[15]}}, half_v};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator to word RAM with RMW; optional LSU_MISALIGN_TRAP_EN
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q;
    state_e            state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic              unsigned_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept;
    logic              req_err;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] load_data;

    assign accept = req_valid && req_ready;

    // Classify the incoming request; errors skip the memory entirely.
`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        req_err = (req_size == SZ_RSVD)
               || ((req_size == SZ_HALF) && req_addr[0])
               || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        req_err = (req_size == SZ_RSVD);
    end
`endif

    // State register; reset aborts any transaction in flight, including a pending RMW write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state strobes; only one of mem_read/mem_write is ever high.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (!req_write || (req_size != SZ_WORD)) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD: begin
                mem_read = 1'b1;
                state_d  = write_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                mem_write = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture on accept, and read-data capture at the end of the RD cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
                err_q      <= req_err;
            end
            if (state_q == ST_RD) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    lsu_lane_align u_align (
        .old_word    (rdata_q),
        .wdata       (wdata_q),
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    // The RAM only decodes word addresses; low bits are always presented as zero.
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = mem_write ? merged_word : '0;
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid && !err_q && !write_q) ? load_data : '0;

endmodule
